// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-division scan controller for a 4-digit 7-segment mm:ss display.
//   Keeps a tear-free display snapshot that is updated only at frame
//   boundaries. Each digit gets one slot of SCAN_DIV clocks. The first clock
//   of every slot is dead time with all digits off. Leading-zero suppression
//   on d3/d2 and per-digit blink blank a digit by sending 4'hF to the decoder.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous, active-high reset
//   en_i           scan enable (0: display dark, counters hold)
//   load_i         1-cycle strobe, capture bcd_in_i as the next display value
//   bcd_in_i[15:0] {d3,d2,d1,d0}, d0 rightmost, nibble > 9 shows blank
//   blink_mask_i   bit i = 1: digit i blinks
//   lz_sup_i       suppress leading zeros on d3/d2
//   seg_code_o     4-bit code to the segment decoder, 4'hF = blank
//   an_o           active-low digit enables, at most one low
//   dp_n_o         active-low colon, lit while digit 2 is enabled
//   frame_done_o   1-cycle pulse after each frame boundary
module seg_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [15:0] bcd_in_i,
    input  logic [3:0]  blink_mask_i,
    input  logic        lz_sup_i,
    output logic [3:0]  seg_code_o,
    output logic [3:0]  an_o,
    output logic        dp_n_o,
    output logic        frame_done_o
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             hidden_q, hidden_d;   // 1 = blink phase hidden
    logic [15:0]      disp_q, disp_d;
    logic [15:0]      pending_q, pending_d;
    logic             pend_q, pend_d;
    logic [3:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             dp_n_q, dp_n_d;
    logic             fd_q, fd_d;

    logic             boundary;
    logic [3:0]       nib;
    logic             blank;

    always_comb begin
        div_d     = div_q;
        idx_d     = idx_q;
        blk_cnt_d = blk_cnt_q;
        hidden_d  = hidden_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        boundary  = 1'b0;
        nib       = 4'hF;
        blank     = 1'b0;
        seg_d     = 4'hF;
        an_d      = 4'b1111;
        dp_n_d    = 1'b1;
        fd_d      = 1'b0;

        // Slot / digit counters
        if (en_i) begin
            if (div_q == DIV_LAST) begin
                div_d    = '0;
                idx_d    = idx_q + 2'd1;
                boundary = (idx_q == 2'd3);
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        // Blink phase advances once per frame
        if (boundary) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d = '0;
                hidden_d  = ~hidden_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end

        // Shadow update: a load on the boundary edge bypasses the pending
        // register so the value is visible in the very next slot.
        if (boundary && load_i) begin
            disp_d    = bcd_in_i;
            pending_d = bcd_in_i;
            pend_d    = 1'b0;
        end else if (boundary && pend_q) begin
            disp_d = pending_q;
            pend_d = 1'b0;
        end else if (load_i) begin
            pending_d = bcd_in_i;
            pend_d    = 1'b1;
        end

        // Outputs are computed from the post-edge state so they line up
        // with the div/idx the registers are about to hold.
        case (idx_d)
            2'd0:    nib = disp_d[3:0];
            2'd1:    nib = disp_d[7:4];
            2'd2:    nib = disp_d[11:8];
            default: nib = disp_d[15:12];
        endcase

        blank = (hidden_d && blink_mask_i[idx_d])
              || (lz_sup_i && idx_d == 2'd3 && disp_d[15:12] == 4'h0)
              || (lz_sup_i && idx_d == 2'd2 && disp_d[15:12] == 4'h0
                           && disp_d[11:8] == 4'h0);

        if (en_i) begin
            seg_d  = blank ? 4'hF : nib;
            an_d   = (div_d == '0) ? 4'b1111 : ~(4'b0001 << idx_d);
            dp_n_d = !((div_d != '0) && (idx_d == 2'd2));
            fd_d   = boundary;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q     <= '0;
            idx_q     <= '0;
            blk_cnt_q <= '0;
            hidden_q  <= 1'b0;
            disp_q    <= 16'hFFFF;
            pending_q <= 16'hFFFF;
            pend_q    <= 1'b0;
            seg_q     <= 4'hF;
            an_q      <= 4'b1111;
            dp_n_q    <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            blk_cnt_q <= blk_cnt_d;
            hidden_q  <= hidden_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            dp_n_q    <= dp_n_d;
            fd_q      <= fd_d;
        end
    end

    assign seg_code_o   = seg_q;
    assign an_o         = an_q;
    assign dp_n_o       = dp_n_q;
    assign frame_done_o = fd_q;

endmodule
